// File: rtl/uart_frame_rx.sv
// uart_frame_rx: assembles SYNC-led frames from the UART byte stream into
// num1/num2/cin and presents them with a valid/ready handshake. Partial frames
// are abandoned after an inter-byte timeout. Bytes arriving while a frame is
// held are dropped and counted.
// Optional trailing XOR checksum byte: define FRAME_CHECKSUM_EN.
//
// state     | meaning
// S_HUNT    | waiting for SYNC_BYTE, other bytes ignored
// S_PAYLOAD | collecting payload bytes, inter-byte timer running
// S_HOLD    | complete frame presented, waiting for i_frame_ready
module uart_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 43400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_data_available,
  input  logic        i_frame_ready,
  output logic        o_frame_valid,
  output logic [31:0] o_num1,
  output logic [31:0] o_num2,
  output logic        o_cin,
  output logic        o_timeout,
  output logic        o_overrun,
  output logic        o_frame_error,
  output logic [7:0]  o_drop_count
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_HOLD} state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_sh_num1;
  logic [31:0]   r_sh_num2;
  logic          r_valid;
  logic [31:0]   r_num1;
  logic [31:0]   r_num2;
  logic          r_cin;
  logic          r_timeout;
  logic          r_overrun;
  logic [7:0]    r_drop;
`ifdef FRAME_CHECKSUM_EN
  logic          r_sh_cin;
  logic [7:0]    r_xor;
  logic          r_frame_error;
`endif

  logic       w_sync;
  logic [7:0] w_drop_next;
  logic [4:0] w_byte_lsb;

  assign w_sync      = i_data_available && (i_data == SYNC_BYTE);
  assign w_drop_next = (r_drop == 8'hFF) ? r_drop : r_drop + 8'd1;
  assign w_byte_lsb  = {r_idx[1:0], 3'b000};

  // Frame FSM: hunt, payload collection with timeout, hold until transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_HUNT;
      r_idx     <= '0;
      r_timer   <= '0;
      r_sh_num1 <= '0;
      r_sh_num2 <= '0;
      r_valid   <= 1'b0;
      r_num1    <= '0;
      r_num2    <= '0;
      r_cin     <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_drop    <= '0;
`ifdef FRAME_CHECKSUM_EN
      r_sh_cin      <= 1'b0;
      r_xor         <= '0;
      r_frame_error <= 1'b0;
`endif
    end else begin
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_frame_error <= 1'b0;
`endif
      case (r_state)
        S_HUNT: begin
          if (w_sync) begin
            r_state <= S_PAYLOAD;
            r_idx   <= '0;
            r_timer <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_xor   <= '0;
`endif
          end
        end
        S_PAYLOAD: begin
          if (i_data_available) begin
            r_timer <= '0;
            r_idx   <= r_idx + 4'd1;
            if (r_idx < 4'd4)
              r_sh_num1[w_byte_lsb +: 8] <= i_data;
            else if (r_idx < 4'd8)
              r_sh_num2[w_byte_lsb +: 8] <= i_data;
`ifdef FRAME_CHECKSUM_EN
            r_xor <= r_xor ^ i_data;
            if (r_idx == 4'd8)
              r_sh_cin <= i_data[0];
            if (r_idx == LAST_IDX) begin
              if (i_data == r_xor) begin
                r_num1  <= r_sh_num1;
                r_num2  <= r_sh_num2;
                r_cin   <= r_sh_cin;
                r_valid <= 1'b1;
                r_state <= S_HOLD;
              end else begin
                r_frame_error <= 1'b1;
                r_drop        <= w_drop_next;
                r_state       <= S_HUNT;
              end
            end
`else
            if (r_idx == LAST_IDX) begin
              r_num1  <= r_sh_num1;
              r_num2  <= r_sh_num2;
              r_cin   <= i_data[0];
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
`endif
          end else if (r_timer == TIMER_LAST) begin
            r_timer   <= '0;
            r_timeout <= 1'b1;
            r_drop    <= w_drop_next;
            r_state   <= S_HUNT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_HOLD: begin
          if (i_frame_ready) begin
            r_valid <= 1'b0;
            if (w_sync) begin
              r_state <= S_PAYLOAD;
              r_idx   <= '0;
              r_timer <= '0;
`ifdef FRAME_CHECKSUM_EN
              r_xor   <= '0;
`endif
            end else begin
              r_state <= S_HUNT;
            end
          end else if (i_data_available) begin
            r_overrun <= 1'b1;
            r_drop    <= w_drop_next;
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  assign o_frame_valid = r_valid;
  assign o_num1        = r_num1;
  assign o_num2        = r_num2;
  assign o_cin         = r_cin;
  assign o_timeout     = r_timeout;
  assign o_overrun     = r_overrun;
  assign o_drop_count  = r_drop;
`ifdef FRAME_CHECKSUM_EN
  assign o_frame_error = r_frame_error;
`else
  assign o_frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed bench for uart_frame_rx (short timeout for speed).
module tb_uart_frame_rx;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_dav = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_num1;
  logic [31:0] o_num2;
  logic        o_cin;
  logic        o_timeout;
  logic        o_overrun;
  logic        o_frame_error;
  logic [7:0]  o_drop;

  uart_frame_rx #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_data           (i_data),
    .i_data_available (i_dav),
    .i_frame_ready    (i_ready),
    .o_frame_valid    (o_valid),
    .o_num1           (o_num1),
    .o_num2           (o_num2),
    .o_cin            (o_cin),
    .o_timeout        (o_timeout),
    .o_overrun        (o_overrun),
    .o_frame_error    (o_frame_error),
    .o_drop_count     (o_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_to = 0, n_ov = 0, n_fe = 0;
  logic [7:0] acc;

  typedef struct {
    logic [31:0] n1;
    logic [31:0] n2;
    logic [7:0]  flags;
    logic        exp_cin;
  } vec_t;
  vec_t vecs [4];

  always @(negedge clk) begin
    if (o_timeout)     n_to++;
    if (o_overrun)     n_ov++;
    if (o_frame_error) n_fe++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_data = b;
    i_dav  = 1'b1;
    tick();
    i_dav  = 1'b0;
  endtask

  task automatic send_pl(input logic [7:0] b);
    acc = acc ^ b;
    send_byte(b);
  endtask

  // payload bytes (no SYNC) plus checksum in the checksum build
  task automatic send_body(input logic [31:0] n1, input logic [31:0] n2, input logic [7:0] fl);
    acc = 8'h00;
    for (int i = 0; i < 4; i++) send_pl(n1[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_pl(n2[8*i +: 8]);
    send_pl(fl);
`ifdef FRAME_CHECKSUM_EN
    send_byte(acc);
`endif
  endtask

  task automatic send_frame(input logic [31:0] n1, input logic [31:0] n2, input logic [7:0] fl);
    send_byte(SYNC);
    send_body(n1, n2, fl);
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] n1, input logic [31:0] n2,
                           input logic cin);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_num1"}, o_num1, n1);
    chk({tag, "_num2"}, o_num2, n2);
    chk({tag, "_cin"}, {31'd0, o_cin}, {31'd0, cin});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int exp_drop;
    int exp_ov;
    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 8'h01, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'hFFFF_FFFF, 8'hFE, 1'b0};
    vecs[2] = '{32'h00A5_00A5, 32'hA5A5_A5A5, 8'hA5, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0000, 8'h03, 1'b1};
    exp_drop = 0;

    // reset state
    repeat (3) tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_num1", o_num1, 32'd0);
    chk("rst_num2", o_num2, 32'd0);
    chk("rst_flags", {28'd0, o_cin, o_timeout, o_overrun, o_frame_error}, 32'd0);
    chk("rst_drop", {24'd0, o_drop}, 32'd0);
    rst_n = 1'b1;
    tick();

    // table-driven frames, consumer always ready
    i_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].n1, vecs[v].n2, vecs[v].flags);
      chk_frame($sformatf("vec%0d", v), vecs[v].n1, vecs[v].n2, vecs[v].exp_cin);
      tick();
      chk($sformatf("vec%0d_drop_valid", v), {31'd0, o_valid}, 32'd0);
    end

    // junk before sync is ignored
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    chk("junk_valid", {31'd0, o_valid}, 32'd0);
    send_frame(32'hCAFE_0001, 32'h0000_BEEF, 8'h00);
    chk_frame("junk", 32'hCAFE_0001, 32'h0000_BEEF, 1'b0);
    tick();

    // strobe on the timer expiry cycle wins
    send_byte(SYNC);
    acc = 8'h00;
    send_pl(8'h11); send_pl(8'h22); send_pl(8'h33); send_pl(8'h44);
    repeat (TO - 1) tick();
    send_pl(8'h55);
    send_pl(8'h66); send_pl(8'h77); send_pl(8'h88); send_pl(8'h01);
`ifdef FRAME_CHECKSUM_EN
    send_byte(acc);
`endif
    chk_frame("race", 32'h4433_2211, 32'h8877_6655, 1'b1);
    chk("race_no_timeout", n_to, 0);
    tick();

    // timeout after 5 payload bytes
    send_byte(SYNC);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    repeat (TO - 1) tick();
    chk("to_early", {31'd0, o_timeout}, 32'd0);
    tick();
    exp_drop = 1;
    chk("to_pulse", {31'd0, o_timeout}, 32'd1);
    chk("to_drop", {24'd0, o_drop}, exp_drop);
    tick();
    chk("to_pulse_end", {31'd0, o_timeout}, 32'd0);
    send_frame(32'h0000_0010, 32'h0000_0020, 8'h01);
    chk_frame("after_to", 32'h0000_0010, 32'h0000_0020, 1'b1);
    tick();
    chk("to_count", n_to, 1);

    // overrun while holding
    i_ready = 1'b0;
    send_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 8'h00);
    tick(); tick();
    chk_frame("hold", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    send_byte(8'h77);
    exp_drop = 2;
    chk("ov_pulse", {31'd0, o_overrun}, 32'd1);
    chk("ov_drop", {24'd0, o_drop}, exp_drop);
    chk_frame("ov_stable", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    tick();
    chk("ov_pulse_end", {31'd0, o_overrun}, 32'd0);
    send_byte(SYNC);
    exp_drop = 3;
    chk("ov_sync_drop", {24'd0, o_drop}, exp_drop);
    i_ready = 1'b1;
    tick();
    chk("ov_release", {31'd0, o_valid}, 32'd0);
    chk("ov_count", n_ov, 2);

    // SYNC on the transfer cycle starts the next frame directly
    i_ready = 1'b0;
    send_frame(32'h0101_0101, 32'h0202_0202, 8'h00);
    chk("b2b_first_valid", {31'd0, o_valid}, 32'd1);
    i_ready = 1'b1;
    send_byte(SYNC);
    chk("b2b_valid_drop", {31'd0, o_valid}, 32'd0);
    send_body(32'h0303_0303, 32'h0404_0404, 8'h01);
    chk_frame("b2b", 32'h0303_0303, 32'h0404_0404, 1'b1);
    chk("b2b_no_ov", n_ov, 2);
    tick();

    // checksum error
`ifdef FRAME_CHECKSUM_EN
    send_byte(SYNC);
    acc = 8'h00;
    send_pl(8'h09); send_pl(8'h00); send_pl(8'h00); send_pl(8'h00);
    send_pl(8'h08); send_pl(8'h00); send_pl(8'h00); send_pl(8'h00);
    send_pl(8'h01);
    send_byte(~acc);
    exp_drop = 4;
    chk("fe_pulse", {31'd0, o_frame_error}, 32'd1);
    chk("fe_valid", {31'd0, o_valid}, 32'd0);
    chk("fe_num1_kept", o_num1, 32'h0303_0303);
    chk("fe_drop", {24'd0, o_drop}, exp_drop);
    tick();
    chk("fe_pulse_end", {31'd0, o_frame_error}, 32'd0);
    chk("fe_count", n_fe, 1);
`else
    chk("fe_tied", {31'd0, o_frame_error}, 32'd0);
    chk("fe_count", n_fe, 0);
`endif

    // drop counter saturation
    i_ready = 1'b0;
    send_frame(32'h5555_AAAA, 32'h0000_0007, 8'h01);
    exp_ov = n_ov + 260;
    repeat (260) send_byte(8'h11);
    tick();
    chk("sat_drop", {24'd0, o_drop}, 32'd255);
    chk("sat_ov_count", n_ov, exp_ov);
    chk_frame("sat_hold", 32'h5555_AAAA, 32'h0000_0007, 1'b1);
    i_ready = 1'b1;
    tick();
    chk("sat_release", {31'd0, o_valid}, 32'd0);

    // asynchronous reset mid-frame
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(8'hEE);
    exp_ov = n_ov;
    rst_n = 1'b0;
    #2;
    chk("mrst_num1", o_num1, 32'd0);
    chk("mrst_num2", o_num2, 32'd0);
    chk("mrst_bits", {28'd0, o_valid, o_cin, o_timeout, o_overrun}, 32'd0);
    chk("mrst_drop", {24'd0, o_drop}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_frame(32'h0BB0_0CC0, 32'h1357_9BDF, 8'h01);
    chk_frame("post_rst", 32'h0BB0_0CC0, 32'h1357_9BDF, 1'b1);
    tick();
    chk("post_rst_drop", {24'd0, o_drop}, 32'd0);
    chk("post_rst_pulses", n_to * 1000 + n_ov - exp_ov, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
